// File: rtl/pwm_fade_sequencer.sv
// Two-channel LED duty sequencer: SET/FADE/BREATHE/OFF commands ramp each duty word by one LSB per step.
// Optional PWM_SEQ_PERIOD_SYNC_EN defers command apply to the next period_tick; otherwise apply is immediate.
module pwm_fade_chan #(
  parameter int PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_apply,
  input  logic                 i_step,
  input  logic [1:0]           i_mode,
  input  logic [PWM_WIDTH-1:0] i_level,
  output logic [PWM_WIDTH-1:0] o_duty,
  output logic                 o_busy
);
  typedef enum logic [2:0] {ST_IDLE, ST_FADE_UP, ST_FADE_DN, ST_BR_UP, ST_BR_DN} state_t;

  localparam logic [1:0] MODE_SET  = 2'b00;
  localparam logic [1:0] MODE_FADE = 2'b01;
  localparam logic [1:0] MODE_BR   = 2'b10;
  localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

  state_t               r_state, w_nxt_state;
  logic [PWM_WIDTH-1:0] r_duty, w_nxt_duty;
  logic [PWM_WIDTH-1:0] r_lvl, w_nxt_lvl;
  logic [PWM_WIDTH-1:0] w_inc, w_dec;

  // Saturating neighbours of the current duty
  assign w_inc = (r_duty == DUTY_MAX) ? r_duty : r_duty + PWM_WIDTH'(1);
  assign w_dec = (r_duty == '0)       ? r_duty : r_duty - PWM_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_lvl   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_duty  <= w_nxt_duty;
      r_lvl   <= w_nxt_lvl;
    end
  end

  // A command wins over a step landing on the same tick
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_duty  = r_duty;
    w_nxt_lvl   = r_lvl;
    if (i_apply) begin
      case (i_mode)
        MODE_SET: begin
          w_nxt_duty  = i_level;
          w_nxt_state = ST_IDLE;
        end
        MODE_FADE: begin
          w_nxt_lvl = i_level;
          if (r_duty < i_level)      w_nxt_state = ST_FADE_UP;
          else if (r_duty > i_level) w_nxt_state = ST_FADE_DN;
          else                       w_nxt_state = ST_IDLE;
        end
        MODE_BR: begin
          w_nxt_lvl = i_level;
          if (i_level == '0) begin
            w_nxt_duty  = '0;
            w_nxt_state = ST_IDLE;
          end else if (r_duty >= i_level) begin
            w_nxt_state = ST_BR_DN;
          end else begin
            w_nxt_state = ST_BR_UP;
          end
        end
        default: begin
          w_nxt_duty  = '0;
          w_nxt_state = ST_IDLE;
        end
      endcase
    end else if (i_step) begin
      case (r_state)
        ST_FADE_UP: begin
          w_nxt_duty = w_inc;
          if (w_inc >= r_lvl) w_nxt_state = ST_IDLE;
        end
        ST_FADE_DN: begin
          w_nxt_duty = w_dec;
          if (w_dec <= r_lvl) w_nxt_state = ST_IDLE;
        end
        ST_BR_UP: begin
          w_nxt_duty = w_inc;
          if (w_inc >= r_lvl) w_nxt_state = ST_BR_DN;
        end
        ST_BR_DN: begin
          w_nxt_duty = w_dec;
          if (w_dec == '0) w_nxt_state = ST_BR_UP;
        end
        default: ;
      endcase
    end
  end

  assign o_duty = r_duty;
  assign o_busy = (r_state != ST_IDLE);
endmodule

module pwm_fade_sequencer #(
  parameter int PWM_WIDTH = 4,
  parameter int STEP_DIV  = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   period_tick,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_chan,
  input  logic [1:0]             cmd_mode,
  input  logic [PWM_WIDTH-1:0]   cmd_level,
  output logic [2*PWM_WIDTH-1:0] duty_out,
  output logic [1:0]             busy
);
  localparam int NUM_CH = 2;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(STEP_DIV - 1);

  logic                  r_pend_vld;
  logic                  r_pend_chan;
  logic [1:0]            r_pend_mode;
  logic [PWM_WIDTH-1:0]  r_pend_level;
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  w_accept, w_apply, w_step;
  logic [NUM_CH-1:0][PWM_WIDTH-1:0] w_duty;

  assign cmd_ready = !r_pend_vld;
  assign w_accept  = cmd_valid && !r_pend_vld;
`ifdef PWM_SEQ_PERIOD_SYNC_EN
  // Slot is only drained on a period boundary so duty never changes mid-period
  assign w_apply = r_pend_vld && period_tick;
`else
  assign w_apply = r_pend_vld;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_vld   <= 1'b0;
      r_pend_chan  <= 1'b0;
      r_pend_mode  <= 2'b00;
      r_pend_level <= '0;
    end else if (w_accept) begin
      r_pend_vld   <= 1'b1;
      r_pend_chan  <= cmd_chan;
      r_pend_mode  <= cmd_mode;
      r_pend_level <= cmd_level;
    end else if (w_apply) begin
      r_pend_vld   <= 1'b0;
    end
  end

  assign w_step = period_tick && (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_div <= '0;
    else if (period_tick) r_div <= w_step ? '0 : r_div + DIV_WIDTH'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_fade_chan #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .i_apply (w_apply && (int'(r_pend_chan) == g)),
      .i_step  (w_step),
      .i_mode  (r_pend_mode),
      .i_level (r_pend_level),
      .o_duty  (w_duty[g]),
      .o_busy  (busy[g])
    );
  end

  assign duty_out = w_duty;
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer (PWM_WIDTH=4, STEP_DIV=2); adapts to PWM_SEQ_PERIOD_SYNC_EN.
module tb_pwm_fade_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       period_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_chan = 1'b0;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_level = 4'd0;
  logic [7:0] duty_out;
  logic [1:0] busy;
  int total = 0;
  int bad   = 0;

  localparam logic [1:0] M_SET = 2'b00, M_FADE = 2'b01, M_BR = 2'b10, M_OFF = 2'b11;

  pwm_fade_sequencer #(.PWM_WIDTH(4), .STEP_DIV(2), .DIV_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .period_tick(period_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
    .cmd_mode(cmd_mode), .cmd_level(cmd_level), .duty_out(duty_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic do_reset();
    #2 reset_n = 1'b0;
    cmd_valid = 1'b0;
    period_tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic pulse_tick();
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
  endtask

  // Offers a command at the current negedge; returns on the negedge after acceptance.
  task automatic send_cmd(input logic ch, input logic [1:0] m, input logic [3:0] lv);
    int n = 0;
    cmd_valid = 1'b1; cmd_chan = ch; cmd_mode = m; cmd_level = lv;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL send_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic apply_cmd(input logic ch, input logic [1:0] m, input logic [3:0] lv);
    send_cmd(ch, m, lv);
`ifdef PWM_SEQ_PERIOD_SYNC_EN
    pulse_tick();
`else
    @(negedge clk);
`endif
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    total++;
    if ({duty_out, busy, cmd_ready} !== {8'h00, 2'b00, 1'b1}) begin
      bad++; $display("FAIL reset_async: duty=%h busy=%b rdy=%b required 00 00 1", duty_out, busy, cmd_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({duty_out, busy, cmd_ready} !== {8'h00, 2'b00, 1'b1}) begin
      bad++; $display("FAIL reset_release: duty=%h busy=%b rdy=%b required 00 00 1", duty_out, busy, cmd_ready);
    end
  endtask

  task automatic test_set();
    do_reset();
`ifdef PWM_SEQ_PERIOD_SYNC_EN
    // accepted alongside a tick: must wait for the next one
    cmd_valid = 1'b1; cmd_chan = 1'b0; cmd_mode = M_SET; cmd_level = 4'd9; period_tick = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; period_tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (cmd_ready !== 1'b0 || duty_out !== 8'h00) begin
        bad++; $display("FAIL set_wait: rdy=%b duty=%h required 0 00", cmd_ready, duty_out);
      end
      @(negedge clk);
    end
    pulse_tick();
`else
    send_cmd(1'b0, M_SET, 4'd9);
    total++;
    if (cmd_ready !== 1'b0 || duty_out !== 8'h00) begin
      bad++; $display("FAIL set_pending: rdy=%b duty=%h required 0 00", cmd_ready, duty_out);
    end
    @(negedge clk);
`endif
    total++;
    if (duty_out !== 8'h09 || busy !== 2'b00 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL set_applied: duty=%h busy=%b rdy=%b required 09 00 1", duty_out, busy, cmd_ready);
    end
  endtask

  task automatic test_fade();
    int exp;
    do_reset();
    send_cmd(1'b1, M_FADE, 4'd3);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      pulse_tick();
      exp = (k / 2 > 3) ? 3 : k / 2;
      total++;
      if (duty_out[7:4] !== 4'(exp) || busy[1] !== (exp != 3) || duty_out[3:0] !== 4'd0) begin
        bad++; $display("FAIL fade_up tick%0d: ch2=%0d busy=%b required ch2=%0d busy1=%b", k, duty_out[7:4], busy, exp, exp != 3);
      end
    end
  endtask

  task automatic test_breathe();
    int seq [7] = '{0, 1, 2, 1, 0, 1, 2};
    do_reset();
    send_cmd(1'b0, M_BR, 4'd2);
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      pulse_tick();
      total++;
      if (duty_out[3:0] !== 4'(seq[k / 2]) || busy[0] !== 1'b1) begin
        bad++; $display("FAIL breathe tick%0d: ch1=%0d busy=%b required ch1=%0d busy0=1", k, duty_out[3:0], busy, seq[k / 2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_valid = 1'b1; cmd_chan = 1'b0; cmd_mode = M_SET; cmd_level = 4'd4;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: rdy=%b required 1", cmd_ready); end
    @(negedge clk);
    cmd_chan = 1'b1; cmd_level = 4'd7;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_slot: rdy=%b required 0", cmd_ready); end
`ifdef PWM_SEQ_PERIOD_SYNC_EN
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || duty_out !== 8'h00) begin
      bad++; $display("FAIL b2b_held: rdy=%b duty=%h required 0 00", cmd_ready, duty_out);
    end
    pulse_tick();
`else
    @(negedge clk);
`endif
    total++;
    if (duty_out !== 8'h04 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_first: duty=%h rdy=%b required 04 1", duty_out, cmd_ready);
    end
    @(negedge clk); cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0 || duty_out !== 8'h04) begin
      bad++; $display("FAIL b2b_second_pending: rdy=%b duty=%h required 0 04", cmd_ready, duty_out);
    end
`ifdef PWM_SEQ_PERIOD_SYNC_EN
    pulse_tick();
`else
    @(negedge clk);
`endif
    total++;
    if (duty_out !== 8'h74 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_second: duty=%h rdy=%b required 74 1", duty_out, cmd_ready);
    end
  endtask

  task automatic test_fade_down_off();
    int exp [6] = '{15, 14, 14, 13, 13, 13};
    do_reset();
    apply_cmd(1'b1, M_SET, 4'd15);
    total++;
    if (duty_out !== 8'hF0 || busy !== 2'b00) begin
      bad++; $display("FAIL fdn_set: duty=%h busy=%b required f0 00", duty_out, busy);
    end
    apply_cmd(1'b1, M_FADE, 4'd13);
    total++;
    if (duty_out !== 8'hF0 || busy !== 2'b10) begin
      bad++; $display("FAIL fdn_start: duty=%h busy=%b required f0 10", duty_out, busy);
    end
    for (int k = 0; k < 6; k++) begin
      pulse_tick();
      total++;
      if (duty_out[7:4] !== 4'(exp[k]) || busy[1] !== (exp[k] != 13)) begin
        bad++; $display("FAIL fade_down tick%0d: ch2=%0d busy=%b required %0d", k + 1, duty_out[7:4], busy, exp[k]);
      end
    end
    apply_cmd(1'b1, M_OFF, 4'd9);
    total++;
    if (duty_out !== 8'h00 || busy !== 2'b00) begin
      bad++; $display("FAIL off: duty=%h busy=%b required 00 00", duty_out, busy);
    end
    apply_cmd(1'b1, M_FADE, 4'd0);
    total++;
    if (duty_out !== 8'h00 || busy !== 2'b00) begin
      bad++; $display("FAIL fade_equal: duty=%h busy=%b required 00 00", duty_out, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_cmd(1'b0, M_FADE, 4'd15);
    @(negedge clk);
    for (int k = 0; k < 6; k++) pulse_tick();
    total++;
    if (duty_out !== 8'h03 || busy !== 2'b01) begin
      bad++; $display("FAIL mid_ramp: duty=%h busy=%b required 03 01", duty_out, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (duty_out !== 8'h00 || busy !== 2'b00 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset: duty=%h busy=%b rdy=%b required 00 00 1", duty_out, busy, cmd_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 4; k++) pulse_tick();
    total++;
    if (duty_out !== 8'h00 || busy !== 2'b00) begin
      bad++; $display("FAIL no_resume: duty=%h busy=%b required 00 00", duty_out, busy);
    end
  endtask

  task automatic test_apply_timing();
    do_reset();
    send_cmd(1'b1, M_SET, 4'd5);
    total++;
    if (duty_out[7:4] !== 4'd0) begin
      bad++; $display("FAIL timing_accept: ch2=%0d required 0", duty_out[7:4]);
    end
`ifdef PWM_SEQ_PERIOD_SYNC_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (duty_out[7:4] !== 4'd0 || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL timing_no_tick: ch2=%0d rdy=%b required 0 0", duty_out[7:4], cmd_ready);
      end
    end
    pulse_tick();
`else
    @(negedge clk);
`endif
    total++;
    if (duty_out[7:4] !== 4'd5 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL timing_apply: ch2=%0d rdy=%b required 5 1", duty_out[7:4], cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_fade();
    test_breathe();
    test_back_to_back();
    test_fade_down_off();
    test_reset_mid();
    test_apply_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
